// File: rtl/iopmp_pkg.sv
// Shared types and helpers for the sequential IOPMP checker.
package iopmp_pkg;

    // Address-matching mode of one IOPMP entry.
    typedef enum logic [1:0] {
        ADDR_OFF   = 2'd0,
        ADDR_TOR   = 2'd1,
        ADDR_NA4   = 2'd2,
        ADDR_NAPOT = 2'd3
    } addr_mode_e;

    // Per-entry permission bits, laid out to line up with the {write, read} access field.
    typedef struct packed {
        logic w;
        logic r;
    } perm_t;

    // Checker control states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RESP
    } chk_state_e;

    // How the deciding entry relates to the access range.
    typedef enum logic [1:0] {
        MATCH_NONE,
        MATCH_PARTIAL,
        MATCH_FULL
    } match_e;

    // Partial means the region touches the access but does not contain all of it.
    function automatic match_e classify_match(input logic overlap, input logic full);
        if (!overlap) begin
            return MATCH_NONE;
        end else if (full) begin
            return MATCH_FULL;
        end else begin
            return MATCH_PARTIAL;
        end
    endfunction

endpackage

// File: rtl/iopmp_range_entry.sv
// One lane of the checker: decodes a single entry's region and compares it
// against the access range [lo, {carry,hi}].
module iopmp_range_entry
    import iopmp_pkg::*;
#(
    parameter int PLEN    = 56,
    parameter int PMP_LEN = 54
) (
    input  logic [PLEN-1:0]    lo,
    input  logic [PLEN-1:0]    hi,
    input  logic               carry,
    input  logic [PMP_LEN-1:0] cfg_addr,
    input  logic [PMP_LEN-1:0] prev_addr,
    input  addr_mode_e         mode,
    output logic               overlap_o,
    output logic               full_o
);

    localparam int CW = $clog2(PMP_LEN + 1);
    localparam logic [PLEN:0] ONE   = (PLEN + 1)'(1);
    localparam logic [PLEN:0] THREE = (PLEN + 1)'(3);

    logic [CW-1:0] ones;
    logic          seen_zero;
    logic [PLEN:0] base;
    logic [PLEN:0] last;
    logic [PLEN:0] mask;
    logic          region_valid;
    logic [PLEN:0] lo_ext;
    logic [PLEN:0] hi_ext;

    // Count trailing ones of the entry address; this sets the NAPOT region size.
    always_comb begin
        ones      = '0;
        seen_zero = 1'b0;
        for (int i = 0; i < PMP_LEN; i++) begin
            if (!seen_zero && cfg_addr[i]) begin
                ones = ones + CW'(1);
            end else begin
                seen_zero = 1'b1;
            end
        end
    end

    // Decode the inclusive byte range [base, last] covered by this entry, one bit wider than the address.
    always_comb begin
        base         = '0;
        last         = '0;
        mask         = '0;
        region_valid = 1'b0;
        case (mode)
            ADDR_TOR: begin
                if (prev_addr < cfg_addr) begin
                    region_valid = 1'b1;
                    base         = {1'b0, prev_addr, 2'b00};
                    last         = {1'b0, cfg_addr, 2'b00} - ONE;
                end
            end
            ADDR_NA4: begin
                region_valid = 1'b1;
                base         = {1'b0, cfg_addr, 2'b00};
                last         = base + THREE;
            end
            ADDR_NAPOT: begin
                region_valid = 1'b1;
                if (ones >= CW'(PMP_LEN - 1)) begin
                    base = '0;
                    last = {1'b0, {PLEN{1'b1}}};
                end else begin
                    mask = ~((ONE << (ones + CW'(3))) - ONE);
                    base = {1'b0, cfg_addr, 2'b00} & mask;
                    last = base | ~mask;
                end
            end
            default: begin
                region_valid = 1'b0;
            end
        endcase
    end

    // A carry pushes the top of the access beyond the address space, so it can never be contained.
    always_comb begin
        lo_ext    = {1'b0, lo};
        hi_ext    = {carry, hi};
        overlap_o = region_valid && (lo_ext <= last) && (hi_ext >= base);
        full_o    = region_valid && (lo_ext >= base) && (hi_ext <= last);
    end

endmodule

// File: rtl/iopmp_seq_checker.sv
// Sequential IOPMP checker: walks the entry table LANES entries per cycle and
// reports the decision of the lowest-index overlapping entry.
module iopmp_seq_checker
    import iopmp_pkg::*;
#(
    parameter int PLEN       = 56,
    parameter int PMP_LEN    = 54,
    parameter int NR_ENTRIES = 16,
    parameter int LANES      = 4,
    parameter int LEN_W      = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [PLEN-1:0]               req_addr_i,
    input  logic [LEN_W-1:0]              req_len_i,
    input  logic [1:0]                    req_access_i,
    input  logic [NR_ENTRIES*PMP_LEN-1:0] cfg_addr_i,
    input  logic [NR_ENTRIES*2-1:0]       cfg_mode_i,
    input  logic [NR_ENTRIES*2-1:0]       cfg_perm_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic                          rsp_allow_o,
    output logic                          rsp_hit_o,
    output logic                          rsp_partial_o,
    output logic [$clog2(NR_ENTRIES)-1:0] rsp_entry_o
);

    localparam int G  = NR_ENTRIES / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int EW = $clog2(NR_ENTRIES);

    chk_state_e        state;
    chk_state_e        next_state;
    logic [PLEN-1:0]   addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        access_q;
    logic [GW-1:0]     g_q;
    logic              allow_q;
    logic              hit_q;
    logic              partial_q;
    logic [EW-1:0]     entry_q;

    logic [PLEN:0]     hi_ext;
    logic [PMP_LEN-1:0] lane_cfg     [LANES];
    logic [PMP_LEN-1:0] lane_prev    [LANES];
    addr_mode_e        lane_mode    [LANES];
    perm_t             lane_perm    [LANES];
    logic [LANES-1:0]  lane_overlap;
    logic [LANES-1:0]  lane_full;

    logic              grp_hit;
    logic [LW-1:0]     hit_lane;
    logic [EW-1:0]     hit_entry;
    perm_t             hit_perm;
    match_e            hit_match;
    logic              hit_allow;
    logic              last_group;

    // End of the access range; the extra top bit is the wrap-around carry.
    assign hi_ext = {1'b0, addr_q} + {{(PLEN + 1 - LEN_W){1'b0}}, len_q};

    // Route the current group's entries (and each one's predecessor for TOR) into the lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            int idx;
            idx          = int'(g_q) * LANES + l;
            lane_cfg[l]  = cfg_addr_i[idx*PMP_LEN +: PMP_LEN];
            lane_mode[l] = addr_mode_e'(cfg_mode_i[idx*2 +: 2]);
            lane_perm[l] = perm_t'(cfg_perm_i[idx*2 +: 2]);
            if (idx == 0) begin
                lane_prev[l] = '0;
            end else begin
                lane_prev[l] = cfg_addr_i[(idx-1)*PMP_LEN +: PMP_LEN];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        iopmp_range_entry #(
            .PLEN    (PLEN),
            .PMP_LEN (PMP_LEN)
        ) u_entry (
            .lo        (addr_q),
            .hi        (hi_ext[PLEN-1:0]),
            .carry     (hi_ext[PLEN]),
            .cfg_addr  (lane_cfg[l]),
            .prev_addr (lane_prev[l]),
            .mode      (lane_mode[l]),
            .overlap_o (lane_overlap[l]),
            .full_o    (lane_full[l])
        );
    end

    // Pick the lowest-index overlapping lane and form its decision.
    always_comb begin
        grp_hit  = 1'b0;
        hit_lane = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_overlap[l]) begin
                grp_hit  = 1'b1;
                hit_lane = LW'(l);
            end
        end
        hit_entry  = EW'(int'(g_q) * LANES + int'(hit_lane));
        hit_perm   = lane_perm[hit_lane];
        hit_match  = classify_match(grp_hit, lane_full[hit_lane]);
        hit_allow  = (hit_match == MATCH_FULL) &&
                     ((access_q & ~{hit_perm.w, hit_perm.r}) == 2'b00);
        last_group = (g_q == GW'(G - 1));
    end

    // Control state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, walk groups in SCAN, hold the result in RESP.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (grp_hit || last_group) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Request capture, group counter and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            len_q     <= '0;
            access_q  <= '0;
            g_q       <= '0;
            allow_q   <= 1'b0;
            hit_q     <= 1'b0;
            partial_q <= 1'b0;
            entry_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        addr_q   <= req_addr_i;
                        len_q    <= req_len_i;
                        access_q <= req_access_i;
                        g_q      <= '0;
                    end
                end
                ST_SCAN: begin
                    if (grp_hit) begin
                        allow_q   <= hit_allow;
                        hit_q     <= 1'b1;
                        partial_q <= (hit_match == MATCH_PARTIAL);
                        entry_q   <= hit_entry;
                    end else if (last_group) begin
                        allow_q   <= 1'b0;
                        hit_q     <= 1'b0;
                        partial_q <= 1'b0;
                        entry_q   <= '0;
                    end else begin
                        g_q <= g_q + GW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result fields read 0 whenever no response is being presented.
    always_comb begin
        req_ready_o   = (state == ST_IDLE) && !rst_i;
        rsp_valid_o   = (state == ST_RESP);
        rsp_allow_o   = rsp_valid_o && allow_q;
        rsp_hit_o     = rsp_valid_o && hit_q;
        rsp_partial_o = rsp_valid_o && partial_q;
        rsp_entry_o   = rsp_valid_o ? entry_q : '0;
    end

endmodule

// File: tb/tb_iopmp_seq_checker.sv
// Directed testbench for iopmp_seq_checker with hand-computed expectations.
module tb_iopmp_seq_checker;
    import iopmp_pkg::*;

    localparam int PLEN       = 56;
    localparam int PMP_LEN    = 54;
    localparam int NR_ENTRIES = 16;
    localparam int LANES      = 4;
    localparam int LEN_W      = 8;

    logic                          clk_i;
    logic                          rst_i;
    logic                          req_valid_i;
    logic                          req_ready_o;
    logic [PLEN-1:0]               req_addr_i;
    logic [LEN_W-1:0]              req_len_i;
    logic [1:0]                    req_access_i;
    logic [NR_ENTRIES*PMP_LEN-1:0] cfg_addr_i;
    logic [NR_ENTRIES*2-1:0]       cfg_mode_i;
    logic [NR_ENTRIES*2-1:0]       cfg_perm_i;
    logic                          rsp_valid_o;
    logic                          rsp_ready_i;
    logic                          rsp_allow_o;
    logic                          rsp_hit_o;
    logic                          rsp_partial_o;
    logic [3:0]                    rsp_entry_o;

    int n_checks;
    int n_fail;
    int latency;

    iopmp_seq_checker #(
        .PLEN       (PLEN),
        .PMP_LEN    (PMP_LEN),
        .NR_ENTRIES (NR_ENTRIES),
        .LANES      (LANES),
        .LEN_W      (LEN_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_len_i     (req_len_i),
        .req_access_i  (req_access_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_mode_i    (cfg_mode_i),
        .cfg_perm_i    (cfg_perm_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_allow_o   (rsp_allow_o),
        .rsp_hit_o     (rsp_hit_o),
        .rsp_partial_o (rsp_partial_o),
        .rsp_entry_o   (rsp_entry_o)
    );

    // Free-running 10-unit clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Program one table entry.
    task automatic set_entry(input int idx, input logic [PMP_LEN-1:0] addr, input addr_mode_e mode, input logic [1:0] perm);
        cfg_addr_i[idx*PMP_LEN +: PMP_LEN] = addr;
        cfg_mode_i[idx*2 +: 2]             = mode;
        cfg_perm_i[idx*2 +: 2]             = perm;
    endtask

    task automatic clear_table();
        cfg_addr_i = '0;
        cfg_mode_i = '0;
        cfg_perm_i = '0;
    endtask

    // Handshake one request and wait (bounded) for rsp_valid_o; reports the cycle it rose in.
    task automatic applyStimulus(input logic [PLEN-1:0] addr, input logic [LEN_W-1:0] len,
                                 input logic [1:0] access, output int cyc);
        @(negedge clk_i);
        req_addr_i   = addr;
        req_len_i    = len;
        req_access_i = access;
        req_valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        cyc = 1;
        while (!rsp_valid_o && cyc < 20) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
    endtask

    // Consume the pending response.
    task automatic release_rsp();
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        req_len_i    = '0;
        req_access_i = '0;
        rsp_ready_i  = 1'b0;
        clear_table();

        // Reset state.
        #12;
        checkOutput("reset_req_ready", req_ready_o, 0);
        checkOutput("reset_rsp_valid", rsp_valid_o, 0);
        checkOutput("reset_rsp_allow", rsp_allow_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("idle_req_ready", req_ready_o, 1);

        // Entry 0 NAPOT 0x0000-0x0FFF, read only; in-range read.
        set_entry(0, 54'h1FF, ADDR_NAPOT, 2'b01);
        applyStimulus(56'h100, 8'd3, 2'b01, latency);
        checkOutput("napot_rd_latency", latency, 2);
        checkOutput("napot_rd_allow", rsp_allow_o, 1);
        checkOutput("napot_rd_hit", rsp_hit_o, 1);
        checkOutput("napot_rd_entry", rsp_entry_o, 0);
        checkOutput("napot_rd_partial", rsp_partial_o, 0);
        checkOutput("napot_rd_ready_busy", req_ready_o, 0);
        release_rsp();
        checkOutput("napot_after_release", rsp_valid_o, 0);

        // Same entry, write: permission denied.
        applyStimulus(56'h100, 8'd3, 2'b10, latency);
        checkOutput("napot_wr_allow", rsp_allow_o, 0);
        checkOutput("napot_wr_hit", rsp_hit_o, 1);
        checkOutput("napot_wr_entry", rsp_entry_o, 0);
        checkOutput("napot_wr_partial", rsp_partial_o, 0);
        release_rsp();

        // Entry 5 TOR 0x1000-0x1FFF (entry 4 only supplies the bottom).
        clear_table();
        set_entry(4, 54'h400, ADDR_OFF, 2'b00);
        set_entry(5, 54'h800, ADDR_TOR, 2'b11);
        applyStimulus(56'h1FFC, 8'd7, 2'b01, latency);
        checkOutput("tor_part_latency", latency, 3);
        checkOutput("tor_part_partial", rsp_partial_o, 1);
        checkOutput("tor_part_allow", rsp_allow_o, 0);
        checkOutput("tor_part_hit", rsp_hit_o, 1);
        checkOutput("tor_part_entry", rsp_entry_o, 5);
        release_rsp();
        applyStimulus(56'h1000, 8'hFF, 2'b11, latency);
        checkOutput("tor_full_allow", rsp_allow_o, 1);
        checkOutput("tor_full_partial", rsp_partial_o, 0);
        checkOutput("tor_full_entry", rsp_entry_o, 5);
        release_rsp();
        applyStimulus(56'h2000, 8'd3, 2'b01, latency);
        checkOutput("tor_above_hit", rsp_hit_o, 0);
        release_rsp();

        // All entries off: default deny after the full walk, held while rsp_ready_i is low.
        clear_table();
        applyStimulus(56'h1234, 8'd0, 2'b01, latency);
        checkOutput("nohit_latency", latency, 5);
        for (int i = 0; i < 3; i++) begin
            checkOutput("nohit_valid_held", rsp_valid_o, 1);
            checkOutput("nohit_hit", rsp_hit_o, 0);
            checkOutput("nohit_allow", rsp_allow_o, 0);
            checkOutput("nohit_entry", rsp_entry_o, 0);
            checkOutput("nohit_req_ready", req_ready_o, 0);
            @(posedge clk_i);
            #1;
        end
        release_rsp();

        // Priority: entry 2 NA4 @0x20 no permissions beats entry 9 NAPOT 0x0-0xFFF RW.
        set_entry(2, 54'h8, ADDR_NA4, 2'b00);
        set_entry(9, 54'h1FF, ADDR_NAPOT, 2'b11);
        applyStimulus(56'h20, 8'd3, 2'b01, latency);
        checkOutput("prio_latency", latency, 2);
        checkOutput("prio_entry", rsp_entry_o, 2);
        checkOutput("prio_allow", rsp_allow_o, 0);
        checkOutput("prio_hit", rsp_hit_o, 1);
        release_rsp();
        applyStimulus(56'h40, 8'd3, 2'b01, latency);
        checkOutput("fallthru_latency", latency, 4);
        checkOutput("fallthru_entry", rsp_entry_o, 9);
        checkOutput("fallthru_allow", rsp_allow_o, 1);
        release_rsp();

        // Reset asserted mid-scan drops the request.
        clear_table();
        @(negedge clk_i);
        req_addr_i   = 56'h500;
        req_len_i    = 8'd0;
        req_access_i = 2'b01;
        req_valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("midscan_rst_valid", rsp_valid_o, 0);
        checkOutput("midscan_rst_ready", req_ready_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("post_rst_ready", req_ready_o, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
        end
        checkOutput("post_rst_no_rsp", rsp_valid_o, 0);

        // Access wrapping past the top of the address space against a whole-space entry.
        set_entry(0, {PMP_LEN{1'b1}}, ADDR_NAPOT, 2'b11);
        applyStimulus({PLEN{1'b1}}, 8'd1, 2'b01, latency);
        checkOutput("wrap_latency", latency, 2);
        checkOutput("wrap_hit", rsp_hit_o, 1);
        checkOutput("wrap_partial", rsp_partial_o, 1);
        checkOutput("wrap_allow", rsp_allow_o, 0);
        checkOutput("wrap_entry", rsp_entry_o, 0);
        release_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
